// File: rtl/sys_reset_seq.sv
// sys_reset_seq: system reset sequencer.
// Combines the raw board reset, a debounced user button, software and CPU-trap
// requests into staged resets. The bus is released first and the CPU follows
// STAGE_GAP cycles later.
//
// Ports:
//   clk        in  system clock (PLL clk0_out)
//   resetn     in  asynchronous active-low board reset
//   btn_n      in  raw user reset button, active low, asynchronous
//   soft_rst   in  single-cycle software reset request (honoured in RUN only)
//   trap       in  CPU trap (honoured in RUN only, when TRAP_RESET = 1)
//   bus_rst    out active-high interconnect/peripheral reset
//   cpu_resetn out active-low CPU reset
//   rst_cause  out last reset cause: 0 power-on, 1 button, 2 software, 3 trap
//   rst_busy   out high while the sequence has not reached RUN
module sys_reset_seq #(
  parameter int unsigned POR_CYCLES      = 1024,
  parameter int unsigned STAGE_GAP       = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter bit          TRAP_RESET      = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       btn_n,
  input  logic       soft_rst,
  input  logic       trap,
  output logic       bus_rst,
  output logic       cpu_resetn,
  output logic [1:0] rst_cause,
  output logic       rst_busy
);

  localparam int unsigned CntMax = (POR_CYCLES > STAGE_GAP) ? POR_CYCLES : STAGE_GAP;
  localparam int unsigned CntW   = $clog2(CntMax);
  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CntW-1:0] PorLast = CntW'(POR_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(STAGE_GAP - 1);
  localparam logic [DbW-1:0]  DbLimit = DbW'(DEBOUNCE_CYCLES);

  localparam logic [1:0] CausePor  = 2'd0;
  localparam logic [1:0] CauseBtn  = 2'd1;
  localparam logic [1:0] CauseSoft = 2'd2;
  localparam logic [1:0] CauseTrap = 2'd3;

  typedef enum logic [1:0] {StHold, StBusUp, StRun} state_e;

  // Internal reset: asserted asynchronously, released after two clean edges.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Button synchronizer and debounce state
  logic [1:0]      btn_sync_q;
  logic            stable_q, stable_d;
  logic [DbW-1:0]  db_cnt_q, db_cnt_d;
  logic            press_q, press_d;

  // Sequencer state
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      cause_q, cause_d;
  logic            bus_rst_q, cpu_resetn_q, busy_q;

  always_comb begin
    db_cnt_d = db_cnt_q;
    stable_d = stable_q;
    if (btn_sync_q[1] == stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbLimit) begin
      stable_d = btn_sync_q[1];
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    // Only a press (1 -> 0) requests a reset; a release is silent.
    press_d = stable_q & ~stable_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;

    unique case (state_q)
      StHold: begin
        if (!stable_q) begin
          // Holding the button keeps the system parked at the start of HOLD.
          cnt_d = '0;
        end else if (cnt_q == PorLast) begin
          state_d = StBusUp;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBusUp: begin
        if (cnt_q == GapLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        cnt_d = '0;
      end
      default: begin
        state_d = StHold;
        cnt_d   = '0;
      end
    endcase

    // Triggers override the sequence; priority button > software > trap.
    if (press_q) begin
      state_d = StHold;
      cnt_d   = '0;
      cause_d = CauseBtn;
    end else if (soft_rst && (state_q == StRun)) begin
      state_d = StHold;
      cnt_d   = '0;
      cause_d = CauseSoft;
    end else if (TRAP_RESET && trap && (state_q == StRun)) begin
      state_d = StHold;
      cnt_d   = '0;
      cause_d = CauseTrap;
    end
  end

  // Button synchronizer runs from the raw reset so it is settled at release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_sync_q <= 2'b11;
    end else begin
      btn_sync_q <= {btn_sync_q[0], btn_n};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stable_q     <= 1'b1;
      db_cnt_q     <= '0;
      press_q      <= 1'b0;
      state_q      <= StHold;
      cnt_q        <= '0;
      cause_q      <= CausePor;
      bus_rst_q    <= 1'b1;
      cpu_resetn_q <= 1'b0;
      busy_q       <= 1'b1;
    end else if (!rst_int_n) begin
      stable_q     <= 1'b1;
      db_cnt_q     <= '0;
      press_q      <= 1'b0;
      state_q      <= StHold;
      cnt_q        <= '0;
      cause_q      <= CausePor;
      bus_rst_q    <= 1'b1;
      cpu_resetn_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      stable_q     <= stable_d;
      db_cnt_q     <= db_cnt_d;
      press_q      <= press_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cause_q      <= cause_d;
      // Outputs decoded from next state so they are registered and glitch-free.
      bus_rst_q    <= (state_d == StHold);
      cpu_resetn_q <= (state_d == StRun);
      busy_q       <= (state_d != StRun);
    end
  end

  assign bus_rst    = bus_rst_q;
  assign cpu_resetn = cpu_resetn_q;
  assign rst_cause  = cause_q;
  assign rst_busy   = busy_q;

endmodule
